wb_burst_ram: RTL and testbench
===============================

// Module: wb_burst_ram
// PURPOSE
//  Burst-capable memory responder: the slave end of the CPU memory-master bus (address/burstcount/byteenable,
//  waitrequest, readdatavalid). Holds a 2**ADDR_WIDTH x 32 synchronous RAM. Serves as on-chip RAM and as the
//  bench target for the memory master. Programmable stall exercises master waitrequest handling.
// PARAMETERS
//  ADDR_WIDTH   10  word-address bits; depth = 2**ADDR_WIDTH dwords
//  WAIT_CYCLES  0   waitrequest-high cycles inserted before each accepted command/write beat (0..15)
// PORTS
//  clk                 in   1   clock
//  rst_n               in   1   asynchronous active-low reset
//  wb_address_i        in   32  byte address; [1:0] ignored, [ADDR_WIDTH+1:2] = word index, upper bits alias
//  wb_writedata_i      in   32  write data, one dword per beat
//  wb_byteenable_i     in   4   per-beat byte lanes for writes; ignored for reads
//  wb_burstcount_i     in   3   beats per burst, sampled on first beat/command only; 0 treated as 1
//  wb_write_i          in   1   write request / beat valid
//  wb_read_i           in   1   read command
//  wb_waitrequest_o    out  1   1 = request not accepted this cycle
//  wb_readdatavalid_o  out  1   read beat valid
//  wb_readdata_o       out  32  read beat data
//  protocol_error_o    out  1   sticky flag: master protocol violation seen
// BEHAVIOUR
//  Reset (async): state=IDLE, stall_cnt=WAIT_CYCLES, readdatavalid=0, readdata=0, protocol_error=0,
//   waitrequest=(WAIT_CYCLES!=0). RAM contents are not reset, retained across reset.
//  waitrequest = (state==READ) | (stall_cnt!=0); depends on registers only, never on inputs.
//  accept = (wb_read_i|wb_write_i) & ~wb_waitrequest_o.
//  stall_cnt: decrements each cycle while nonzero, request asserted and state!=READ.
//   Reloads to WAIT_CYCLES on every accept and on READ->IDLE.
//  States:
//   IDLE:
//    - write accept: RAM[idx] written per byteenable; latch idx+1 and remaining=burstcount-1
//      (burstcount 0 → 1). remaining==0 → stay IDLE, else → WRITE.
//    - read accept (write low): latch idx; remaining=burstcount (0 → 1) → READ.
//    - read&write together: write wins, read ignored, protocol_error set.
//   WRITE:
//    - each write accept writes next word (latched idx, +1 per beat) with that beat's byteenable.
//    - address/burstcount inputs ignored; remaining-1; remaining reaching 0 → IDLE.
//    - write low mid-burst: idle cycles, no beat, burst continues later.
//    - read high in WRITE: ignored, protocol_error set.
//   READ:
//    - RAM read issued on accept; readdatavalid=1 every cycle from the cycle after accept,
//      beats back-to-back, data = RAM[idx], RAM[idx+1], ...
//    - after last beat → IDLE; waitrequest drops next cycle (subject to stall).
//    - read input level ignored.
//  Word index wraps modulo 2**ADDR_WIDTH within a burst. readdata holds last beat when readdatavalid=0.
//  Write and read of same word never overlap (one burst at a time). Read returns RAM contents after all
//   previously accepted writes.
//  Reset mid-burst: outputs return to reset values immediately; remaining beats discarded.
// TESTING
//  1 WAIT=0: write burst 4 @0x100, data A0..A3, BE=F -> 4 beats accepted on 4 consecutive cycles;
//    read burst 4 @0x100 -> readdatavalid cycles 1..4 after accept, data A0..A3.
//  2 Write 0x11223344 BE=F @0x200, then 0xAABBCCDD BE=0101 @0x200 -> read @0x200 returns 0x11BB33DD.
//  3 WAIT=2: write burst 2 -> each beat sees waitrequest high 2 cycles, accepted on 3rd;
//    read command held 3 cycles before accept.
//  4 Write burst 3 @0x40 with 2-cycle write-low gap after beat 1, address driven 0x999 during gap
//    -> words at 0x40/0x44/0x48 written, nothing else changed.
//  5 ADDR_WIDTH=4: read burst 3 @word 15 -> words 15, 0, 1; burstcount 0 -> exactly 1 beat.
//  6 rst_n low after 2 of 4 read beats -> readdatavalid 0 at once, IDLE, RAM intact;
//    read during WRITE -> protocol_error_o=1, stays 1 until reset.

Source files
------------

// File: rtl/wb_burst_ram.sv
// Burst memory slave: 2**ADDR_WIDTH x 32 synchronous RAM behind an address/burstcount/waitrequest bus.
// Latency: read beats begin the cycle after command accept and stream back-to-back; writes land on accept.
// Backpressure: waitrequest is registered only: high during the stall countdown and for a whole read burst.
module wb_burst_ram #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] wb_address_i,
  input  logic [31:0] wb_writedata_i,
  input  logic [3:0]  wb_byteenable_i,
  input  logic [2:0]  wb_burstcount_i,
  input  logic        wb_write_i,
  input  logic        wb_read_i,
  output logic        wb_waitrequest_o,
  output logic        wb_readdatavalid_o,
  output logic [31:0] wb_readdata_o,
  output logic        protocol_error_o
);

  localparam int         DEPTH        = 1 << ADDR_WIDTH;
  localparam logic [3:0] STALL_RELOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [3:0]            stall_cnt, stall_nxt;
  logic [ADDR_WIDTH-1:0] idx, idx_nxt;
  logic [2:0]            remaining, remaining_nxt;
  logic                  rdv_nxt;
  logic                  perr_nxt;
  logic                  mem_we;
  logic                  mem_re;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [31:0]           mem [DEPTH];

  logic [ADDR_WIDTH-1:0] addr_idx;
  logic [2:0]            burst_len;
  logic                  accept;
  logic                  wr_accept;
  logic                  unused_addr_bits;

  // Upper address bits alias and byte-offset bits are ignored.
  assign addr_idx         = wb_address_i[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{wb_address_i[31:ADDR_WIDTH+2], wb_address_i[1:0]};
  assign burst_len        = (wb_burstcount_i == 3'd0) ? 3'd1 : wb_burstcount_i;

  assign wb_waitrequest_o = (state == READ) | (stall_cnt != 4'd0);
  assign accept           = (wb_read_i | wb_write_i) & ~wb_waitrequest_o;
  assign wr_accept        = wb_write_i & ~wb_waitrequest_o;

  // Next-state, burst bookkeeping and RAM port controls.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    remaining_nxt = remaining;
    rdv_nxt       = 1'b0;
    perr_nxt      = protocol_error_o;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    mem_waddr     = idx;
    mem_raddr     = idx;
    case (state)
      IDLE: begin
        mem_waddr = addr_idx;
        mem_raddr = addr_idx;
        // Simultaneous read and write: the write is served, the read dropped.
        if (wb_read_i && wb_write_i) perr_nxt = 1'b1;
        if (wr_accept) begin
          mem_we        = 1'b1;
          idx_nxt       = addr_idx + 1'b1;
          remaining_nxt = burst_len - 3'd1;
          if (burst_len != 3'd1) state_nxt = WRITE;
        end else if (accept) begin
          // First beat is fetched on the accept edge itself.
          mem_re        = 1'b1;
          rdv_nxt       = 1'b1;
          idx_nxt       = addr_idx + 1'b1;
          remaining_nxt = burst_len - 3'd1;
          state_nxt     = READ;
        end
      end
      WRITE: begin
        if (wb_read_i) perr_nxt = 1'b1;
        if (wr_accept) begin
          mem_we        = 1'b1;
          idx_nxt       = idx + 1'b1;
          remaining_nxt = remaining - 3'd1;
          if (remaining == 3'd1) state_nxt = IDLE;
        end
      end
      READ: begin
        if (remaining != 3'd0) begin
          mem_re        = 1'b1;
          rdv_nxt       = 1'b1;
          idx_nxt       = idx + 1'b1;
          remaining_nxt = remaining - 3'd1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Stall counter only runs down while a request is pending outside a read burst.
    if (accept || (state == READ && state_nxt == IDLE)) begin
      stall_nxt = STALL_RELOAD;
    end else if (stall_cnt != 4'd0 && (wb_read_i || wb_write_i) && state != READ) begin
      stall_nxt = stall_cnt - 4'd1;
    end else begin
      stall_nxt = stall_cnt;
    end
  end

  // Control registers and read data port; reset discards any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      stall_cnt          <= STALL_RELOAD;
      idx                <= '0;
      remaining          <= 3'd0;
      wb_readdatavalid_o <= 1'b0;
      wb_readdata_o      <= 32'h0;
      protocol_error_o   <= 1'b0;
    end else begin
      state              <= state_nxt;
      stall_cnt          <= stall_nxt;
      idx                <= idx_nxt;
      remaining          <= remaining_nxt;
      wb_readdatavalid_o <= rdv_nxt;
      protocol_error_o   <= perr_nxt;
      if (mem_re) wb_readdata_o <= mem[mem_raddr];
    end
  end

  // RAM array: byte-lane writes, contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_byteenable_i[b]) mem[mem_waddr][8*b +: 8] <= wb_writedata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_burst_ram.sv
// Bench for wb_burst_ram: three instances (no stall, 2-cycle stall, 16-word depth) behind one stimulus port.
// Read expectations come from a bench-side memory model and are queued at command time.
// Outputs are sampled on the falling clock edge; inputs change on the falling edge too.
module tb_wb_burst_ram;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  be = 4'h0;
  logic [2:0]  bc = 3'd0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [1:0]  sel = 2'd0;

  logic [2:0]  wr_v, rd_v, wait_v, rdv_v, perr_v;
  logic [31:0] rdata_v [3];
  logic        waitreq, rdv, perr;
  logic [31:0] rdata;

  logic [31:0] model [3][1024];
  logic [31:0] exp_q [$];
  int          vectors = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign wr_v = {sel == 2'd2, sel == 2'd1, sel == 2'd0} & {3{wr}};
  assign rd_v = {sel == 2'd2, sel == 2'd1, sel == 2'd0} & {3{rd}};

  always_comb begin
    waitreq = wait_v[0];
    rdv     = rdv_v[0];
    perr    = perr_v[0];
    rdata   = rdata_v[0];
    case (sel)
      2'd1: begin waitreq = wait_v[1]; rdv = rdv_v[1]; perr = perr_v[1]; rdata = rdata_v[1]; end
      2'd2: begin waitreq = wait_v[2]; rdv = rdv_v[2]; perr = perr_v[2]; rdata = rdata_v[2]; end
      default: ;
    endcase
  end

  wb_burst_ram #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_ram0 (
    .clk(clk), .rst_n(rst_n), .wb_address_i(addr), .wb_writedata_i(wdata),
    .wb_byteenable_i(be), .wb_burstcount_i(bc), .wb_write_i(wr_v[0]), .wb_read_i(rd_v[0]),
    .wb_waitrequest_o(wait_v[0]), .wb_readdatavalid_o(rdv_v[0]), .wb_readdata_o(rdata_v[0]),
    .protocol_error_o(perr_v[0]));

  wb_burst_ram #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) u_ram1 (
    .clk(clk), .rst_n(rst_n), .wb_address_i(addr), .wb_writedata_i(wdata),
    .wb_byteenable_i(be), .wb_burstcount_i(bc), .wb_write_i(wr_v[1]), .wb_read_i(rd_v[1]),
    .wb_waitrequest_o(wait_v[1]), .wb_readdatavalid_o(rdv_v[1]), .wb_readdata_o(rdata_v[1]),
    .protocol_error_o(perr_v[1]));

  wb_burst_ram #(.ADDR_WIDTH(4), .WAIT_CYCLES(0)) u_ram2 (
    .clk(clk), .rst_n(rst_n), .wb_address_i(addr), .wb_writedata_i(wdata),
    .wb_byteenable_i(be), .wb_burstcount_i(bc), .wb_write_i(wr_v[2]), .wb_read_i(rd_v[2]),
    .wb_waitrequest_o(wait_v[2]), .wb_readdatavalid_o(rdv_v[2]), .wb_readdata_o(rdata_v[2]),
    .protocol_error_o(perr_v[2]));

  function automatic int dmask();
    return (sel == 2'd2) ? 15 : 1023;
  endfunction

  function automatic void model_write(input int w, input logic [31:0] d, input logic [3:0] bev);
    int m;
    m = w & dmask();
    for (int b = 0; b < 4; b++) begin
      if (bev[b]) model[sel][m][8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  // Present one request at a falling edge, hold it until accepted; returns stalled cycles.
  task automatic drive_beat(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] bev, input logic [2:0] bcv, output int waits);
    wr = w; rd = r; addr = a; wdata = d; be = bev; bc = bcv;
    waits = 0;
    #1;
    while (waitreq !== 1'b0 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 50) begin
      vectors++; errors++;
      $display("FAIL accept_timeout: waitrequest still %b after %0d cycles, required 0", waitreq, waits);
    end
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
  endtask

  // Pop queued expectations against consecutive read beats, then require the burst to end.
  task automatic drain_read(input int n, input string tag);
    logic [31:0] e;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      e = exp_q.pop_front();
      vectors++;
      if (rdv !== 1'b1) begin
        errors++;
        $display("FAIL %s_valid beat %0d: got %b, required 1", tag, i, rdv);
      end
      vectors++;
      if (rdata !== e) begin
        errors++;
        $display("FAIL %s_data beat %0d: got %h, required %h", tag, i, rdata, e);
      end
    end
    @(negedge clk);
    vectors++;
    if (rdv !== 1'b0) begin
      errors++;
      $display("FAIL %s_end: readdatavalid %b after %0d beats, required 0", tag, rdv, n);
    end
  endtask

  task automatic write_burst(input logic [31:0] a, input logic [2:0] bcv, input logic [31:0] d0,
                             input logic [3:0] bev, output int minw, output int maxw);
    int n, w;
    n = (bcv == 3'd0) ? 1 : int'(bcv);
    minw = 1000; maxw = 0;
    for (int i = 0; i < n; i++) begin
      drive_beat(1'b1, 1'b0, a, d0 + 32'(i), bev, bcv, w);
      model_write(int'(a >> 2) + i, d0 + 32'(i), bev);
      if (w < minw) minw = w;
      if (w > maxw) maxw = w;
    end
  endtask

  task automatic read_burst(input logic [31:0] a, input logic [2:0] bcv, input string tag, output int w);
    int n;
    n = (bcv == 3'd0) ? 1 : int'(bcv);
    for (int i = 0; i < n; i++) exp_q.push_back(model[sel][(int'(a >> 2) + i) & dmask()]);
    drive_beat(1'b0, 1'b1, a, 32'h0, 4'h0, bcv, w);
    drain_read(n, tag);
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      vectors++;
      if (waitreq !== (s == 1)) begin
        errors++; $display("FAIL reset_waitreq inst %0d: got %b, required %b", s, waitreq, s == 1);
      end
      vectors++;
      if (rdv !== 1'b0 || rdata !== 32'h0 || perr !== 1'b0) begin
        errors++; $display("FAIL reset_outputs inst %0d: got rdv=%b data=%h perr=%b, required 0/0/0", s, rdv, rdata, perr);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read_burst();
    int minw, maxw, w;
    sel = 2'd0;
    write_burst(32'h100, 3'd4, 32'hA0, 4'hF, minw, maxw);
    vectors++;
    if (maxw !== 0) begin
      errors++; $display("FAIL wr4_stall: worst beat stalled %0d cycles, required 0", maxw);
    end
    read_burst(32'h100, 3'd4, "rd4", w);
    vectors++;
    if (w !== 0) begin
      errors++; $display("FAIL rd4_stall: got %0d, required 0", w);
    end
    vectors++;
    if (waitreq !== 1'b0) begin
      errors++; $display("FAIL rd4_release: waitrequest %b after burst, required 0", waitreq);
    end
  endtask

  task automatic test_byteenable();
    int minw, maxw, w;
    sel = 2'd0;
    write_burst(32'h200, 3'd1, 32'h11223344, 4'hF, minw, maxw);
    write_burst(32'h200, 3'd1, 32'hAABBCCDD, 4'b0101, minw, maxw);
    exp_q.push_back(32'h11BB33DD);
    drive_beat(1'b0, 1'b1, 32'h200, 32'h0, 4'h0, 3'd1, w);
    drain_read(1, "be_merge");
  endtask

  task automatic test_wait_states();
    int minw, maxw, w;
    sel = 2'd1;
    write_burst(32'h080, 3'd2, 32'hB0, 4'hF, minw, maxw);
    vectors++;
    if (minw !== 2 || maxw !== 2) begin
      errors++; $display("FAIL wait_write: beat stalls min %0d max %0d, required 2 and 2", minw, maxw);
    end
    read_burst(32'h080, 3'd2, "wait_rd", w);
    vectors++;
    if (w !== 2) begin
      errors++; $display("FAIL wait_read: command stalled %0d cycles, required 2", w);
    end
  endtask

  task automatic test_write_gap();
    int minw, maxw, w;
    sel = 2'd0;
    write_burst(32'h03C, 3'd5, 32'h50, 4'hF, minw, maxw);
    write_burst(32'h998, 3'd1, 32'h99, 4'hF, minw, maxw);
    drive_beat(1'b1, 1'b0, 32'h040, 32'hD0, 4'hF, 3'd3, w);
    model_write(32'h040 >> 2, 32'hD0, 4'hF);
    addr = 32'h999; wdata = 32'hDEAD; bc = 3'd7; be = 4'hF;
    repeat (2) @(negedge clk);
    drive_beat(1'b1, 1'b0, 32'h999, 32'hD1, 4'hF, 3'd7, w);
    model_write((32'h040 >> 2) + 1, 32'hD1, 4'hF);
    drive_beat(1'b1, 1'b0, 32'h999, 32'hD2, 4'hF, 3'd7, w);
    model_write((32'h040 >> 2) + 2, 32'hD2, 4'hF);
    read_burst(32'h03C, 3'd5, "gap_rd", w);
    read_burst(32'h998, 3'd1, "gap_alias", w);
  endtask

  task automatic test_wrap();
    int minw, maxw, w;
    sel = 2'd2;
    #1;
    write_burst(32'h038, 3'd4, 32'hC0, 4'hF, minw, maxw);
    read_burst(32'h43C, 3'd3, "wrap_rd", w);
    write_burst(32'h008, 3'd0, 32'hC9, 4'hF, minw, maxw);
    read_burst(32'h008, 3'd0, "bc0_rd", w);
    read_burst(32'h038, 3'd0, "bc0_rd2", w);
  endtask

  task automatic test_reset_mid_burst();
    int minw, maxw, w;
    sel = 2'd0;
    #1;
    write_burst(32'h300, 3'd4, 32'h30, 4'hF, minw, maxw);
    drive_beat(1'b0, 1'b1, 32'h300, 32'h0, 4'h0, 3'd4, w);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      vectors++;
      if (rdv !== 1'b1 || rdata !== model[0][(32'h300 >> 2) + i]) begin
        errors++; $display("FAIL rst_beat %0d: got rdv=%b data=%h, required 1 %h", i, rdv, rdata, model[0][(32'h300 >> 2) + i]);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (rdv !== 1'b0 || rdata !== 32'h0 || waitreq !== 1'b0) begin
      errors++; $display("FAIL rst_async: got rdv=%b data=%h wait=%b, required 0 0 0", rdv, rdata, waitreq);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    read_burst(32'h300, 3'd4, "rst_intact", w);
  endtask

  task automatic test_protocol_error();
    int w;
    sel = 2'd0;
    #1;
    vectors++;
    if (perr !== 1'b0) begin
      errors++; $display("FAIL perr_clear: got %b, required 0", perr);
    end
    drive_beat(1'b1, 1'b0, 32'h500, 32'hE0, 4'hF, 3'd2, w);
    model_write(32'h500 >> 2, 32'hE0, 4'hF);
    rd = 1'b1; addr = 32'h600;
    @(negedge clk);
    rd = 1'b0;
    vectors++;
    if (perr !== 1'b1 || rdv !== 1'b0) begin
      errors++; $display("FAIL perr_write_rd: got perr=%b rdv=%b, required 1 0", perr, rdv);
    end
    drive_beat(1'b1, 1'b0, 32'h600, 32'hE1, 4'hF, 3'd2, w);
    model_write((32'h500 >> 2) + 1, 32'hE1, 4'hF);
    read_burst(32'h500, 3'd2, "perr_rd", w);
    vectors++;
    if (perr !== 1'b1) begin
      errors++; $display("FAIL perr_sticky: got %b, required 1", perr);
    end
    sel = 2'd2;
    #1;
    drive_beat(1'b1, 1'b1, 32'h014, 32'hF5, 4'hF, 3'd1, w);
    model_write(32'h014 >> 2, 32'hF5, 4'hF);
    vectors++;
    if (perr !== 1'b1 || rdv !== 1'b0) begin
      errors++; $display("FAIL perr_rw_idle: got perr=%b rdv=%b, required 1 0", perr, rdv);
    end
    read_burst(32'h014, 3'd1, "rw_write_wins", w);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (perr !== 1'b0) begin
      errors++; $display("FAIL perr_reset: got %b, required 0", perr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write_read_burst();
    test_byteenable();
    test_wait_states();
    test_write_gap();
    test_wrap();
    test_reset_mid_burst();
    test_protocol_error();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
